// File: rtl/gpio_pad_sync_if.sv
// GPIO pad interface: push-pull/open-drain pad drive, per-bit input synchroniser,
// optional debounce filter and registered single-cycle rise/fall event pulses.
module gpio_pad_sync_if #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic [WIDTH-1:0] out_pad_o,
    input  logic [WIDTH-1:0] oen_padoen_o,
    input  logic [WIDTH-1:0] od_mode_i,
    input  logic [WIDTH-1:0] deb_en_i,
    inout  wire  [WIDTH-1:0] io_pad,
    output logic [WIDTH-1:0] in_pad_i,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    // A one-cycle filter needs no counter state, but keep a 1-bit counter so the
    // logic stays uniform; with CNT_MAX = 0 it never leaves zero.
    localparam int            CW      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [WIDTH-1:0] drv_en;
    logic [WIDTH-1:0] drv_val;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_lvl;

    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // Open-drain bits only ever pull low; releasing lets the external pull-up win.
    always_comb begin
        drv_en  = (od_mode_i & oen_padoen_o & ~out_pad_o) | (~od_mode_i & oen_padoen_o);
        drv_val = ~od_mode_i & out_pad_o;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign io_pad[i] = drv_en[i] ? drv_val[i] : 1'bz;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= io_pad;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Debounce accepts a new level only after it has differed from the held
    // level for DEB_CYCLES consecutive synced cycles; any return clears the count.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (!deb_en_i[i]) begin
                stable_d[i] = sync_lvl[i];
            end else if (sync_lvl[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync_lvl[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        rise_d = stable_d & ~stable_q;
        fall_d = ~stable_d & stable_q;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign in_pad_i = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: tb/tb_gpio_pad_sync_if.sv
// Directed bench for gpio_pad_sync_if (WIDTH=8, SYNC_STAGES=2, DEB_CYCLES=16)
// with pull-ups and per-bit external pad drivers.
module tb_gpio_pad_sync_if;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] out_pad;
    logic [W-1:0] oen;
    logic [W-1:0] od_mode;
    logic [W-1:0] deb_en;
    logic [W-1:0] ext_en;
    logic [W-1:0] ext_val;
    wire  [W-1:0] pad;
    logic [W-1:0] in_pad;
    logic [W-1:0] rise;
    logic [W-1:0] fall;

    int errors = 0;
    int checks = 0;

    for (genvar i = 0; i < W; i++) begin : g_ext
        pullup pu (pad[i]);
        assign pad[i] = ext_en[i] ? ext_val[i] : 1'bz;
    end

    gpio_pad_sync_if #(.WIDTH(W), .SYNC_STAGES(2), .DEB_CYCLES(16)) dut (
        .PCLK         (clk),
        .PRESETn      (rst_n),
        .out_pad_o    (out_pad),
        .oen_padoen_o (oen),
        .od_mode_i    (od_mode),
        .deb_en_i     (deb_en),
        .io_pad       (pad),
        .in_pad_i     (in_pad),
        .rise_o       (rise),
        .fall_o       (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (in_pad !== 8'h00) begin errors++; $display("FAIL reset_in_pad got=%h exp=00", in_pad); end
        checks++; if (rise !== 8'h00) begin errors++; $display("FAIL reset_rise got=%h exp=00", rise); end
        checks++; if (fall !== 8'h00) begin errors++; $display("FAIL reset_fall got=%h exp=00", fall); end
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (in_pad !== ((k >= 3) ? 8'hFF : 8'h00)) begin
                errors++; $display("FAIL release_in_pad edge=%0d got=%h exp=%h", k, in_pad, (k >= 3) ? 8'hFF : 8'h00);
            end
            checks++;
            if (rise !== ((k == 3) ? 8'hFF : 8'h00)) begin
                errors++; $display("FAIL release_rise edge=%0d got=%h exp=%h", k, rise, (k == 3) ? 8'hFF : 8'h00);
            end
        end
    endtask

    task automatic test_push_pull();
        oen[2] = 1'b1; out_pad[2] = 1'b1;
        #1;
        checks++; if (pad[2] !== 1'b1) begin errors++; $display("FAIL pp_drive1 got=%b exp=1", pad[2]); end
        out_pad[2] = 1'b0;
        #1;
        checks++; if (pad[2] !== 1'b0) begin errors++; $display("FAIL pp_drive0 got=%b exp=0", pad[2]); end
        tick(); tick();
        checks++; if (in_pad[2] !== 1'b1) begin errors++; $display("FAIL pp_early got=%b exp=1", in_pad[2]); end
        tick();
        checks++; if (in_pad[2] !== 1'b0) begin errors++; $display("FAIL pp_in0 got=%b exp=0", in_pad[2]); end
        checks++; if (fall !== 8'h04) begin errors++; $display("FAIL pp_fall got=%h exp=04", fall); end
        tick();
        checks++; if (fall !== 8'h00) begin errors++; $display("FAIL pp_fall_width got=%h exp=00", fall); end
        out_pad[2] = 1'b1;
        tick(); tick(); tick();
        checks++; if (rise !== 8'h04) begin errors++; $display("FAIL pp_rise got=%h exp=04", rise); end
        out_pad[2] = 1'b0;
        tick(); tick(); tick(); tick();
        oen[2] = 1'b0;
        #1;
        checks++; if (pad[2] !== 1'b1) begin errors++; $display("FAIL pp_release_pullup got=%b exp=1", pad[2]); end
        tick(); tick();
        checks++; if (in_pad[2] !== 1'b0) begin errors++; $display("FAIL pp_release_early got=%b exp=0", in_pad[2]); end
        tick();
        checks++; if (in_pad[2] !== 1'b1) begin errors++; $display("FAIL pp_release_in got=%b exp=1", in_pad[2]); end
        checks++; if (rise !== 8'h04) begin errors++; $display("FAIL pp_release_rise got=%h exp=04", rise); end
    endtask

    task automatic test_open_drain();
        od_mode[3] = 1'b1; oen[3] = 1'b1; out_pad[3] = 1'b1;
        #1;
        checks++; if (pad[3] !== 1'b1) begin errors++; $display("FAIL od_release got=%b exp=1", pad[3]); end
        ext_en[3] = 1'b1; ext_val[3] = 1'b0;
        #1;
        checks++; if (pad[3] !== 1'b0) begin errors++; $display("FAIL od_not_driving_high got=%b exp=0", pad[3]); end
        ext_en[3] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if (fall !== 8'h00) begin errors++; $display("FAIL od_idle_fall edge=%0d got=%h exp=00", k, fall); end
        end
        out_pad[3] = 1'b0;
        #1;
        checks++; if (pad[3] !== 1'b0) begin errors++; $display("FAIL od_drive0 got=%b exp=0", pad[3]); end
        tick(); tick(); tick();
        checks++; if (in_pad[3] !== 1'b0) begin errors++; $display("FAIL od_in0 got=%b exp=0", in_pad[3]); end
        checks++; if (fall !== 8'h08) begin errors++; $display("FAIL od_fall got=%h exp=08", fall); end
        tick();
        checks++; if (fall !== 8'h00) begin errors++; $display("FAIL od_fall_width got=%h exp=00", fall); end
        out_pad[3] = 1'b1;
        tick(); tick(); tick();
        checks++; if (rise !== 8'h08) begin errors++; $display("FAIL od_rise got=%h exp=08", rise); end
    endtask

    task automatic test_debounce();
        ext_en[4] = 1'b1; ext_val[4] = 1'b1; deb_en[4] = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        ext_val[4] = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        ext_val[4] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            checks++; if (in_pad[4] !== 1'b1) begin errors++; $display("FAIL deb_glitch_in edge=%0d got=%b exp=1", k, in_pad[4]); end
            checks++; if (fall !== 8'h00) begin errors++; $display("FAIL deb_glitch_fall edge=%0d got=%h exp=00", k, fall); end
            tick();
        end
        ext_val[4] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if (in_pad[4] !== ((k >= 18) ? 1'b0 : 1'b1)) begin
                errors++; $display("FAIL deb_hold_in edge=%0d got=%b exp=%b", k, in_pad[4], (k >= 18) ? 1'b0 : 1'b1);
            end
            checks++;
            if (fall !== ((k == 18) ? 8'h10 : 8'h00)) begin
                errors++; $display("FAIL deb_hold_fall edge=%0d got=%h exp=%h", k, fall, (k == 18) ? 8'h10 : 8'h00);
            end
        end
        ext_val[4] = 1'b1;
        for (int k = 1; k <= 18; k++) tick();
        checks++; if (rise !== 8'h10) begin errors++; $display("FAIL deb_rise got=%h exp=10", rise); end
    endtask

    task automatic test_deb_drop();
        ext_en[5] = 1'b1; ext_val[5] = 1'b1; deb_en[5] = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        ext_val[5] = 1'b0;
        for (int k = 1; k <= 10; k++) tick();
        checks++; if (in_pad[5] !== 1'b1) begin errors++; $display("FAIL drop_before got=%b exp=1", in_pad[5]); end
        deb_en[5] = 1'b0;
        tick();
        checks++; if (in_pad[5] !== 1'b0) begin errors++; $display("FAIL drop_in got=%b exp=0", in_pad[5]); end
        checks++; if (fall !== 8'h20) begin errors++; $display("FAIL drop_fall got=%h exp=20", fall); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if ((rise | fall) !== 8'h00) begin errors++; $display("FAIL drop_extra_event edge=%0d got=%h exp=00", k, rise | fall); end
        end
        deb_en[5] = 1'b1;
        ext_val[5] = 1'b1;
        for (int k = 1; k <= 17; k++) tick();
        checks++; if (in_pad[5] !== 1'b0) begin errors++; $display("FAIL raise_early got=%b exp=0", in_pad[5]); end
        tick();
        checks++; if (rise !== 8'h20) begin errors++; $display("FAIL raise_rise got=%h exp=20", rise); end
    endtask

    task automatic test_reset_mid_count();
        ext_en[6] = 1'b1; ext_val[6] = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        deb_en[6] = 1'b1;
        ext_en[6] = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        rst_n = 1'b0;
        #1;
        checks++; if (in_pad !== 8'h00) begin errors++; $display("FAIL midrst_in_pad got=%h exp=00", in_pad); end
        checks++; if (rise !== 8'h00) begin errors++; $display("FAIL midrst_rise got=%h exp=00", rise); end
        checks++; if (fall !== 8'h00) begin errors++; $display("FAIL midrst_fall got=%h exp=00", fall); end
        deb_en = 8'hFF;
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if (in_pad !== ((k >= 18) ? 8'hFF : 8'h00)) begin
                errors++; $display("FAIL midrst_in edge=%0d got=%h exp=%h", k, in_pad, (k >= 18) ? 8'hFF : 8'h00);
            end
            checks++;
            if (rise !== ((k == 18) ? 8'hFF : 8'h00)) begin
                errors++; $display("FAIL midrst_rise_rel edge=%0d got=%h exp=%h", k, rise, (k == 18) ? 8'hFF : 8'h00);
            end
        end
    endtask

    task automatic test_independent();
        deb_en = 8'h80;
        ext_en[0] = 1'b1; ext_en[7] = 1'b1;
        ext_val[0] = 1'b1; ext_val[7] = 1'b1;
        tick();
        ext_val[0] = 1'b0; ext_val[7] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if (fall !== ((k == 3) ? 8'h01 : (k == 18) ? 8'h80 : 8'h00)) begin
                errors++; $display("FAIL indep_fall edge=%0d got=%h", k, fall);
            end
            checks++; if (rise !== 8'h00) begin errors++; $display("FAIL indep_rise edge=%0d got=%h exp=00", k, rise); end
        end
        checks++; if (in_pad !== 8'h7E) begin errors++; $display("FAIL indep_in got=%h exp=7e", in_pad); end
        deb_en = 8'h00;
        ext_val[0] = 1'b1; ext_val[7] = 1'b1;
        tick(); tick(); tick();
        checks++; if (rise !== 8'h81) begin errors++; $display("FAIL indep_rise_both got=%h exp=81", rise); end
        tick();
        checks++; if ((rise | fall) !== 8'h00) begin errors++; $display("FAIL indep_quiet got=%h exp=00", rise | fall); end
    endtask

    initial begin
        rst_n   = 1'b0;
        out_pad = '0;
        oen     = '0;
        od_mode = '0;
        deb_en  = '0;
        ext_en  = '0;
        ext_val = '0;
        test_reset();
        test_push_pull();
        test_open_drain();
        test_debounce();
        test_deb_drop();
        test_reset_mid_count();
        test_independent();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
